// File: rtl/fragment_write_buffer_pkg.sv
// Shared definitions for the fragment write buffer: framebuffer geometry,
// fragment layout, RGB565 field positions and write FSM state encodings.
package fragment_write_buffer_pkg;

  localparam int FB_WIDTH      = 640;
  localparam int FB_HEIGHT     = 400;
  localparam int FB_NUM_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_WIDTH = 18;

  localparam int COLOR_WIDTH = 64;
  localparam int LANE_WIDTH  = 16;
  localparam int PIX_WIDTH   = 16;
  localparam int FRAG_WIDTH  = FB_ADDR_WIDTH + COLOR_WIDTH;

  // RGB565 field positions inside the packed pixel
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_LSB = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [COLOR_WIDTH-1:0]   color;
  } frag_t;

  // Keep the top bits of the low byte of the R, G and B lanes; alpha is unused.
  function automatic logic [PIX_WIDTH-1:0] pack_rgb565(input logic [COLOR_WIDTH-1:0] color);
    logic [PIX_WIDTH-1:0] pix;
    pix = '0;
    pix[RGB_R_LSB +: 5] = color[0*LANE_WIDTH+3 +: 5];
    pix[RGB_G_LSB +: 6] = color[1*LANE_WIDTH+2 +: 6];
    pix[RGB_B_LSB +: 5] = color[2*LANE_WIDTH+3 +: 5];
    return pix;
  endfunction

endpackage

// File: rtl/fragment_write_buffer_fifo.sv
// Synchronous FIFO holding pending fragments. Push and pop may happen in the
// same cycle, including when full, in which case the occupancy is unchanged.
module sync_fifo
  import fragment_write_buffer_pkg::*;
#(
  parameter int WIDTH = FRAG_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy values; pointers wrap because DEPTH is a power of two.
  always_comb begin
    // NOTE: every signal gets a default before any condition so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array written on push.
  // NOTE: the data array is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fragment_write_buffer.sv
// Fragment write buffer: queues rasterizer fragments, packs colour to RGB565
// and writes them to the framebuffer SRAM, with stall and flush reporting.
module fragment_write_buffer
  import fragment_write_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FB_PIXELS = FB_NUM_PIXELS,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_FragValid,
  input  logic [FB_ADDR_WIDTH-1:0] I_FragAddr,
  input  logic [COLOR_WIDTH-1:0]   I_FragColor,
  input  logic                     I_Flush,
  input  logic                     I_MemReady,
  output logic                     O_Stall,
  output logic                     O_MemWe,
  output logic [FB_ADDR_WIDTH-1:0] O_MemAddr,
  output logic [PIX_WIDTH-1:0]     O_MemData,
  output logic                     O_FlushDone,
  output logic                     O_Busy,
  output logic [CNT_WIDTH-1:0]     O_FragCount,
  output logic [CNT_WIDTH-1:0]     O_DropCount
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_e              state_q, state_d;
  logic [FB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PIX_WIDTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]   frag_cnt_q, frag_cnt_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                   flush_pending_q, flush_pending_d;

  logic                   fifo_full, fifo_empty, pop;
  logic [CW-1:0]          fifo_count;
  logic [FRAG_WIDTH-1:0]  fifo_rd_data;
  frag_t                  head, in_frag;
  logic                   accept, in_range, push, drop, flush_done;

  // A full FIFO can still take a fragment when the head leaves in the same cycle.
  assign O_Stall  = fifo_full && !pop;
  assign accept   = I_FragValid && !O_Stall;
  assign in_range = (32'(I_FragAddr) < FB_PIXELS);
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;

  assign in_frag.addr  = I_FragAddr;
  assign in_frag.color = I_FragColor;
  assign head          = frag_t'(fifo_rd_data);

  sync_fifo #(
    .WIDTH (FRAG_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (I_CLOCK),
    .rst_i     (I_RESET),
    .push_i    (push),
    .wr_data_i (in_frag),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Write FSM: present one fragment at a time, reload back-to-back on each accepted write.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    frag_cnt_d = frag_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (I_MemReady) begin
          frag_cnt_d = frag_cnt_q + CNT_WIDTH'(1);
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      addr_d = head.addr;
      data_d = pack_rgb565(head.color);
    end
  end

  // Drop counting and flush tracking; a repeated flush while pending changes nothing.
  always_comb begin
    drop_cnt_d      = drop ? drop_cnt_q + CNT_WIDTH'(1) : drop_cnt_q;
    flush_done      = flush_pending_q && fifo_empty && (state_q == ST_IDLE) && !push;
    flush_pending_d = flush_done ? 1'b0 : (flush_pending_q || I_Flush);
  end

  // State, write-port and counter registers; reset abandons any in-flight write.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      frag_cnt_q      <= '0;
      drop_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      frag_cnt_q      <= frag_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign O_MemWe     = (state_q == ST_WRITE);
  assign O_MemAddr   = addr_q;
  assign O_MemData   = data_q;
  assign O_FlushDone = flush_done;
  assign O_Busy      = (fifo_count != '0) || (state_q == ST_WRITE);
  assign O_FragCount = frag_cnt_q;
  assign O_DropCount = drop_cnt_q;

endmodule

// File: tb/tb_fragment_write_buffer.sv
// Self-checking bench for fragment_write_buffer: directed scenarios with
// hand-computed values plus randomized traffic against a queue-based model.
module tb_fragment_write_buffer;

  localparam int DEPTH  = 8;
  localparam int PIXELS = 256000;

  logic        I_CLOCK, I_RESET;
  logic        I_FragValid, I_Flush, I_MemReady;
  logic [17:0] I_FragAddr;
  logic [63:0] I_FragColor;
  logic        O_Stall, O_MemWe, O_FlushDone, O_Busy;
  logic [17:0] O_MemAddr;
  logic [15:0] O_MemData, O_FragCount, O_DropCount;

  int n_checks = 0;
  int n_fail   = 0;

  fragment_write_buffer dut (
    .I_CLOCK     (I_CLOCK),
    .I_RESET     (I_RESET),
    .I_FragValid (I_FragValid),
    .I_FragAddr  (I_FragAddr),
    .I_FragColor (I_FragColor),
    .I_Flush     (I_Flush),
    .I_MemReady  (I_MemReady),
    .O_Stall     (O_Stall),
    .O_MemWe     (O_MemWe),
    .O_MemAddr   (O_MemAddr),
    .O_MemData   (O_MemData),
    .O_FlushDone (O_FlushDone),
    .O_Busy      (O_Busy),
    .O_FragCount (O_FragCount),
    .O_DropCount (O_DropCount)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq holds every accepted in-range fragment not yet written; when m_inflight
  // is set, mq[0] is the one currently presented to memory.
  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         mq[$];
  bit          m_inflight = 0;
  bit          m_pending  = 0;
  logic [15:0] m_frag     = '0;
  logic [15:0] m_drop     = '0;

  function automatic logic [15:0] rgb565(input logic [63:0] c);
    int r, g, b;
    r = int'(c[7:0]) / 8;
    g = int'(c[23:16]) / 4;
    b = int'(c[39:32]) / 8;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic int m_fifo_count();
    return mq.size() - (m_inflight ? 1 : 0);
  endfunction

  function automatic bit m_pop();
    return (m_fifo_count() > 0) && (!m_inflight || I_MemReady);
  endfunction

  function automatic bit m_stall();
    return (m_fifo_count() == DEPTH) && !m_pop();
  endfunction

  function automatic bit m_push();
    return I_FragValid && !m_stall() && (int'(I_FragAddr) < PIXELS);
  endfunction

  function automatic bit m_done();
    return m_pending && (mq.size() == 0) && !m_push();
  endfunction

  always @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      mq.delete();
      m_inflight = 0;
      m_pending  = 0;
      m_frag     = '0;
      m_drop     = '0;
    end else begin
      bit pop_now, push_now, acc_now, done_now;
      pop_now  = m_pop();
      push_now = m_push();
      acc_now  = I_FragValid && !m_stall();
      done_now = m_done();
      if (m_inflight && I_MemReady) begin
        void'(mq.pop_front());
        m_frag = m_frag + 16'd1;
      end
      m_inflight = (m_inflight && !I_MemReady) || pop_now;
      if (push_now) mq.push_back('{I_FragAddr, rgb565(I_FragColor)});
      else if (acc_now) m_drop = m_drop + 16'd1;
      m_pending = done_now ? 1'b0 : (m_pending || I_Flush);
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge I_CLOCK) begin
    if (!I_RESET) begin
      check("cmp_stall", O_Stall, m_stall());
      check("cmp_we", O_MemWe, m_inflight);
      if (m_inflight && mq.size() > 0) begin
        check("cmp_addr", O_MemAddr, mq[0].addr);
        check("cmp_data", O_MemData, mq[0].data);
      end
      check("cmp_busy", O_Busy, mq.size() != 0);
      check("cmp_flushdone", O_FlushDone, m_done());
      check("cmp_fragcount", O_FragCount, m_frag);
      check("cmp_dropcount", O_DropCount, m_drop);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic set_inputs(input bit v, input logic [17:0] a, input logic [63:0] c,
                            input bit f, input bit r);
    I_FragValid = v;
    I_FragAddr  = a;
    I_FragColor = c;
    I_Flush     = f;
    I_MemReady  = r;
  endtask

  function automatic logic [63:0] mk_color(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {16'hABCD, 8'h00, b, 8'h00, g, 8'h00, r};
  endfunction

  task automatic drain(input string name);
    int k;
    k = 0;
    while (O_Busy && k < 60) begin
      tick();
      k++;
    end
    check(name, O_Busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    O_MemWe, 1'b0);
    check({tag, "_addr"},  O_MemAddr, 18'h0);
    check({tag, "_data"},  O_MemData, 16'h0);
    check({tag, "_stall"}, O_Stall, 1'b0);
    check({tag, "_busy"},  O_Busy, 1'b0);
    check({tag, "_done"},  O_FlushDone, 1'b0);
    check({tag, "_frag"},  O_FragCount, 16'h0);
    check({tag, "_drop"},  O_DropCount, 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, done_cyc, wr, third_cyc;

    I_RESET = 1'b1;
    set_inputs(0, '0, '0, 0, 0);
    #3;
    check_all_zero("reset");
    tick();
    tick();
    I_RESET = 1'b0;

    // Single fragment: visible on the write port two posedges after it is offered.
    set_inputs(1, 18'h00A0, mk_color(8'hFF, 8'h80, 8'h00), 0, 1);
    tick();
    set_inputs(0, '0, '0, 0, 1);
    #1;
    check("single_we_early", O_MemWe, 1'b0);
    tick();
    check("single_we", O_MemWe, 1'b1);
    check("single_addr", O_MemAddr, 18'h00A0);
    check("single_data", O_MemData, 16'hFC00);
    tick();
    check("single_cnt", O_FragCount, 16'd1);
    check("single_we_off", O_MemWe, 1'b0);

    // Flush while idle and empty pulses on the following cycle only.
    set_inputs(0, '0, '0, 1, 1);
    tick();
    set_inputs(0, '0, '0, 0, 1);
    #1;
    check("flush_idle_pulse", O_FlushDone, 1'b1);
    tick();
    check("flush_idle_clear", O_FlushDone, 1'b0);

    // Out-of-range fragments are counted and never written.
    set_inputs(1, 18'd256000, mk_color(8'h11, 8'h22, 8'h33), 0, 1);
    tick();
    check("drop_busy0", O_Busy, 1'b0);
    set_inputs(1, 18'h3FFFF, mk_color(8'h44, 8'h55, 8'h66), 0, 1);
    tick();
    set_inputs(0, '0, '0, 0, 1);
    #1;
    check("drop_busy1", O_Busy, 1'b0);
    check("drop_we", O_MemWe, 1'b0);
    check("drop_cnt", O_DropCount, 16'd2);

    // Backpressure: one loaded plus eight queued stalls; the tenth is lost.
    for (int i = 0; i < 10; i++) begin
      set_inputs(1, 18'(32'h100 + i), {$urandom, $urandom}, 0, 0);
      #1;
      if (i == 8) check("bp_not_full", O_Stall, 1'b0);
      if (i == 9) check("bp_stall", O_Stall, 1'b1);
      tick();
    end
    set_inputs(0, '0, '0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      #1;
      check("bp_we", O_MemWe, 1'b1);
      check("bp_addr", O_MemAddr, 18'(32'h100 + i));
      tick();
    end
    check("bp_we_done", O_MemWe, 1'b0);
    check("bp_cnt", O_FragCount, 16'd10);

    // Full FIFO with push and pop in the same cycle keeps accepting.
    for (int i = 0; i < 9; i++) begin
      set_inputs(1, 18'(32'h200 + i), {$urandom, $urandom}, 0, 0);
      tick();
    end
    for (int i = 9; i < 14; i++) begin
      set_inputs(1, 18'(32'h200 + i), {$urandom, $urandom}, 0, 1);
      #1;
      check("pp_stall_low", O_Stall, 1'b0);
      tick();
    end
    set_inputs(1, 18'h2FF, {$urandom, $urandom}, 0, 0);
    #1;
    check("pp_stall_high", O_Stall, 1'b1);
    tick();
    set_inputs(0, '0, '0, 0, 1);
    drain("pp_drain");
    check("pp_cnt", O_FragCount, 16'd24);

    // Flush with three fragments and a toggling ready.
    pulses = 0; done_cyc = -1; wr = 0; third_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      set_inputs(c < 3, 18'(32'h300 + c), mk_color(8'(c), 8'h10, 8'h20), c == 3, c[0]);
      #1;
      if (O_FlushDone) begin
        pulses++;
        done_cyc = c;
      end
      if (O_MemWe && I_MemReady) begin
        wr++;
        if (wr == 3) third_cyc = c;
      end
      tick();
    end
    check("flush_pulses", pulses, 1);
    check("flush_writes", wr, 3);
    check("flush_third_write_cyc", third_cyc, 7);
    check("flush_done_cyc", done_cyc, 8);

    // Reset while a write is in flight with four more queued.
    for (int i = 0; i < 5; i++) begin
      set_inputs(1, 18'(32'h400 + i), {$urandom, $urandom}, 0, 0);
      tick();
    end
    set_inputs(0, '0, '0, 0, 0);
    #1;
    check("rst_pre_we", O_MemWe, 1'b1);
    #1;
    I_RESET = 1'b1;
    #1;
    check_all_zero("rst_mid");
    tick();
    I_RESET = 1'b0;
    set_inputs(1, 18'h4AA, mk_color(8'h18, 8'h0C, 8'hF8), 0, 1);
    tick();
    set_inputs(0, '0, '0, 0, 1);
    tick();
    check("rst_after_we", O_MemWe, 1'b1);
    check("rst_after_addr", O_MemAddr, 18'h4AA);
    check("rst_after_data", O_MemData, 16'h187F);
    tick();
    check("rst_after_cnt", O_FragCount, 16'd1);
    check("rst_after_drop", O_DropCount, 16'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [17:0] a;
      if ($urandom_range(0, 9) == 0) a = 18'(256000 + $urandom_range(0, 6143));
      else                           a = 18'($urandom_range(0, 255999));
      set_inputs($urandom_range(0, 9) < 7, a, {$urandom, $urandom},
                 $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);
      tick();
    end
    set_inputs(0, '0, '0, 0, 1);
    drain("rand_drain");
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fragment_write_buffer.md
Name: fragment_write_buffer

Overview:
Downstream stage of the rasterizer. It accepts one fragment per cycle (18-bit pixel address plus 64-bit vector colour) into a small FIFO. Each colour is packed to RGB565 and written into the 640x400 framebuffer SRAM over a ready/write-enable handshake. It raises a stall back to the rasterizer when the FIFO fills, and reports flush completion so the frame stall can be released only after every fragment has landed in memory.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
FB_PIXELS, 256000, framebuffer size (640x400); addresses >= this are dropped
CNT_WIDTH, 16, width of the fragment/drop counters

Ports:
I_CLOCK  in  1  clock; all state updates on posedge
I_RESET  in  1  asynchronous, active-high reset
I_FragValid  in  1  fragment present this cycle
I_FragAddr  in  18  pixel address, y*640+x
I_FragColor  in  64  colour vector, four 16-bit lanes: R=[15:0], G=[31:16], B=[47:32], A=[63:48]
I_Flush  in  1  single-cycle request: drain everything, then report
I_MemReady  in  1  SRAM accepts the current write on this posedge
O_Stall  out  1  FIFO cannot accept a fragment this cycle
O_MemWe  out  1  write request valid
O_MemAddr  out  18  write address
O_MemData  out  16  RGB565 data
O_FlushDone  out  1  one-cycle pulse when a flush completes
O_Busy  out  1  FIFO non-empty or write in flight
O_FragCount  out  CNT_WIDTH  fragments written to memory since reset (wraps)
O_DropCount  out  CNT_WIDTH  fragments dropped as out of range (wraps)

Behaviour:
- Reset (async, immediate): FIFO emptied, pointers 0, FSM to IDLE, all outputs 0, flush-pending cleared. An in-flight write is abandoned.
- Input acceptance: a fragment is accepted on the posedge where I_FragValid=1 and O_Stall=0.
  - Fragments with I_FragAddr >= FB_PIXELS are accepted but not enqueued; O_DropCount increments.
  - Fragments offered while O_Stall=1 are lost. The upstream stage must hold or stop.
- O_Stall is combinational: 1 when count==DEPTH.
  - It also depends on a same-cycle pop: when full and a pop completes this cycle, O_Stall=0, and a simultaneous push+pop keeps the count unchanged.
- Packing: O_MemData = {R[7:3], G[7:2], B[7:3]} from the low byte of each lane. Alpha is ignored.
- FSM states:
  - IDLE: O_MemWe=0. If FIFO non-empty, load the head into the output registers, pop, and go to WRITE.
  - WRITE: O_MemWe=1 with O_MemAddr/O_MemData held stable. On a posedge with I_MemReady=1, O_FragCount increments. Then, if the FIFO is non-empty, load and pop the next entry and stay in WRITE (back-to-back, 1 write/cycle); otherwise go to IDLE.
- Latency: a fragment into an empty FIFO with the FSM in IDLE appears on O_MemWe 2 posedges later (enqueue, then load).
- Flush:
  - I_Flush sets flush_pending.
  - When flush_pending=1, FIFO empty, FSM in IDLE and no push this cycle: O_FlushDone=1 for exactly one cycle and flush_pending clears.
  - I_Flush while already idle and empty gives the pulse on the next cycle.
  - A repeated I_Flush while pending has no extra effect.
- O_Busy = FIFO non-empty or FSM in WRITE.
- Counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package/header (global_def.h): FB_WIDTH=640, FB_HEIGHT=400, FB_PIXELS, FB_ADDR_WIDTH=18, RGB565 field positions, FSM state encodings.
- One natural sub-module, sync_fifo: parameterised width (82 = 18+64) and depth, with push/pop/full/empty/count. Its push and pop are legal in the same cycle when full.
- Packing and the FSM stay in the top level.

Test Plan:
- Single fragment: addr=0x00A0, colour lanes R=0xFF, G=0x80, B=0x00, I_MemReady=1. Required: O_MemWe high 2 cycles later, O_MemAddr=0x00A0, O_MemData=0xFC00, O_FragCount=1.
- Backpressure: hold I_MemReady=0 and push 9 fragments. Required: O_Stall=1 after 8 enqueued (plus 1 loaded), the 10th offered fragment is lost. Then raise I_MemReady: 9 writes on 9 consecutive cycles, in order.
- Range drop: addr=256000 and addr=0x3FFFF. Required: no write, O_DropCount=2, O_Busy stays 0.
- Flush: push 3 fragments, pulse I_Flush, I_MemReady toggling 1/0. Required: O_FlushDone pulses once, the cycle after the 3rd write completes, and not before.
- Simultaneous push+pop when full: the count stays at DEPTH, there is no loss, and the order is preserved.
- Reset mid-write: assert I_RESET while O_MemWe=1 with 4 queued. Required: all outputs 0 immediately, counters 0, the next fragment after release is written normally.
